// File: rtl/riscv_switch_ctrl.sv
// riscv_switch_ctrl: per-master burst/lock tracker feeding the arbiter's
// can_switch input. Blocks regrant inside fixed bursts and locked sequences,
// and forces a switch point after MAX_INCR INCR beats or MAX_BUSY BUSY cycles.
module riscv_switch_ctrl #(
    parameter int unsigned MAX_INCR = 16,
    parameter int unsigned MAX_BUSY = 4
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HMASTLOCK,
    input  logic       HREADY,
    input  logic       HRESP,
    output logic       can_switch,
    output logic       busy,
    output logic [3:0] beats_left,
    output logic       forced_switch
);

    localparam int unsigned IW = $clog2(MAX_INCR + 1);
    localparam int unsigned BW = $clog2(MAX_BUSY + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_INCR, S_LOCKED} state_e;

    state_e        state_q, state_d;
    logic [3:0]    beats_q, beats_d;
    logic [IW-1:0] incr_q, incr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          busy_q;

    logic t_idle, t_busy, t_nonseq, t_seq;
    logic acc, err, in_burst, busy_lim, incr_lim, limit;
    logic start_multi, lock_exit, restart;

    // Remaining beats after the NONSEQ of a fixed-length burst (len-1).
    function automatic logic [3:0] burst_last(input logic [2:0] hb);
        case (hb[2:1])
            2'b01:   return 4'd3;
            2'b10:   return 4'd7;
            2'b11:   return 4'd15;
            default: return 4'd0;
        endcase
    endfunction

    assign t_idle   = (HTRANS == 2'b00);
    assign t_busy   = (HTRANS == 2'b01);
    assign t_nonseq = (HTRANS == 2'b10);
    assign t_seq    = (HTRANS == 2'b11);

    assign acc      = HSEL & HREADY & HTRANS[1];
    // Error handling is tied to this master's selection, like all other state.
    assign err      = HSEL & HRESP & ~HREADY;
    assign in_burst = (state_q == S_BURST) || (state_q == S_INCR);
    assign busy_lim = HSEL & HREADY & in_burst & t_busy & (bcnt_q == BW'(MAX_BUSY - 1));
    assign incr_lim = acc & t_seq & (state_q == S_INCR) & (incr_q == IW'(MAX_INCR - 1));
    assign limit    = ~HRESET & ~err & (busy_lim | incr_lim);

    assign start_multi = acc & t_nonseq & ((HBURST[2:1] != 2'b00) | (HBURST == 3'b001));
    // The cycle that releases a lock is itself a legal switch point.
    assign lock_exit   = (state_q == S_LOCKED) & ~HMASTLOCK & HSEL & HREADY
                         & (HTRANS[1] | t_idle);

    assign forced_switch = limit;
    assign busy          = busy_q;
    assign beats_left    = beats_q;

    // Zero-latency switch-point decision, ordered by priority.
    always_comb begin
        if (HRESET || !HSEL)                                     can_switch = 1'b1;
        else if (err)                                            can_switch = 1'b0;
        else if (HMASTLOCK || (state_q == S_LOCKED && !lock_exit)) can_switch = 1'b0;
        else if (limit)                                          can_switch = 1'b1;
        else if (start_multi)                                    can_switch = 1'b0;
        else if (state_q == S_BURST && !(acc && t_seq && beats_q == 4'd1))
                                                                 can_switch = 1'b0;
        else if (state_q == S_INCR && (t_seq || t_busy))         can_switch = 1'b0;
        else                                                     can_switch = 1'b1;
    end

    // Next-state and counter update; a NONSEQ that ends a burst or lock is
    // folded into the IDLE start decode via 'restart' in the same cycle.
    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        incr_d  = incr_q;
        bcnt_d  = bcnt_q;
        restart = 1'b0;
        if (err) begin
            state_d = S_IDLE;
            beats_d = '0;
            incr_d  = '0;
            bcnt_d  = '0;
        end else if (HSEL && HREADY) begin
            bcnt_d = (in_burst && t_busy) ? bcnt_q + 1'b1 : '0;
            if (limit) begin
                state_d = S_IDLE;
                beats_d = '0;
                incr_d  = '0;
                bcnt_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: restart = acc & t_nonseq;
                    S_BURST: begin
                        if (acc && t_seq) begin
                            if (beats_q == 4'd1) begin
                                state_d = S_IDLE;
                                beats_d = '0;
                            end else begin
                                beats_d = beats_q - 4'd1;
                            end
                        end else if (acc && t_nonseq) begin
                            restart = 1'b1;
                        end else if (t_idle) begin
                            state_d = S_IDLE;
                            beats_d = '0;
                        end
                    end
                    S_INCR: begin
                        if (acc && t_seq) begin
                            if (incr_q != IW'(MAX_INCR)) incr_d = incr_q + 1'b1;
                        end else if (acc && t_nonseq) begin
                            restart = 1'b1;
                        end else if (t_idle) begin
                            state_d = S_IDLE;
                            incr_d  = '0;
                        end
                    end
                    S_LOCKED: begin
                        if (lock_exit) begin
                            if (acc && t_nonseq) restart = 1'b1;
                            else                 state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
                if (restart) begin
                    beats_d = '0;
                    incr_d  = '0;
                    if (HMASTLOCK) begin
                        state_d = S_LOCKED;
                    end else if (HBURST[2:1] != 2'b00) begin
                        state_d = S_BURST;
                        beats_d = burst_last(HBURST);
                    end else if (HBURST == 3'b001) begin
                        state_d = S_INCR;
                        incr_d  = IW'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            beats_q <= '0;
            incr_q  <= '0;
            bcnt_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            incr_q  <= incr_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_riscv_switch_ctrl.sv
// Directed-vector bench for riscv_switch_ctrl. Each stimulus cycle pushes its
// hand-computed expectations into a scoreboard queue; a monitor pops one entry
// per cycle at the falling edge and compares (-1 means "not checked").
module tb_riscv_switch_ctrl;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       HSEL = 1'b1;
    logic [1:0] HTRANS = 2'b00;
    logic [2:0] HBURST = 3'b000;
    logic       HMASTLOCK = 1'b0;
    logic       HREADY = 1'b1;
    logic       HRESP = 1'b0;
    logic       can_switch, busy, forced_switch;
    logic [3:0] beats_left;

    int total = 0;
    int bad = 0;

    typedef struct {
        string nm;
        int    ecs;
        int    efs;
        int    eby;
        int    ebl;
    } exp_t;

    exp_t sb[$];

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, W4 = 3'b011, I8 = 3'b101, W16 = 3'b110;

    riscv_switch_ctrl #(.MAX_INCR(16), .MAX_BUSY(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP),
        .can_switch(can_switch), .busy(busy), .beats_left(beats_left),
        .forced_switch(forced_switch)
    );

    always #5 HCLK = ~HCLK;

    // Drive one cycle of inputs just after the rising edge and record expectations.
    // can_switch/forced_switch refer to this cycle; busy/beats_left to the
    // registered values present during this cycle.
    task automatic step(input bit rst, input bit sel, input logic [1:0] tr,
                        input logic [2:0] hb, input bit lk, input bit rdy, input bit rsp,
                        input string nm, input int ecs, input int efs,
                        input int eby, input int ebl);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESET = rst; HSEL = sel; HTRANS = tr; HBURST = hb;
        HMASTLOCK = lk; HREADY = rdy; HRESP = rsp;
        e.nm = nm; e.ecs = ecs; e.efs = efs; e.eby = eby; e.ebl = ebl;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input int act, input int want);
        if (want >= 0) begin
            total++;
            if (act != want) begin
                bad++;
                $display("FAIL %s.%s got=%0d want=%0d", nm, fld, act, want);
            end
        end
    endtask

    // Monitor: the DUT presents a full set of outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.nm, "can_switch", int'(can_switch), e.ecs);
                cmp(e.nm, "forced_switch", int'(forced_switch), e.efs);
                cmp(e.nm, "busy", int'(busy), e.eby);
                cmp(e.nm, "beats_left", int'(beats_left), e.ebl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(1, 1, IDL, SGL, 0, 1, 0, "rst0", 1, 0, -1, -1);
        step(1, 1, IDL, SGL, 0, 1, 0, "rst1", 1, 0, 0, 0);
        step(0, 1, IDL, SGL, 0, 1, 0, "idle", 1, 0, 0, 0);

        // 1: WRAP4 / INCR4 fixed burst
        step(0, 1, NSQ, W4, 0, 1, 0, "t1b1", 0, 0, 0, 0);
        step(0, 1, SEQ, W4, 0, 1, 0, "t1b2", 0, 0, 1, 3);
        step(0, 1, SEQ, W4, 0, 1, 0, "t1b3", 0, 0, 1, 2);
        step(0, 1, SEQ, W4, 0, 1, 0, "t1b4", 1, 0, 1, 1);
        step(0, 1, IDL, SGL, 0, 1, 0, "t1end", 1, 0, 0, 0);

        // 2: INCR8 with a 3-cycle wait state on beat 3
        step(0, 1, NSQ, I8, 0, 1, 0, "t2b1", 0, 0, 0, 0);
        step(0, 1, SEQ, I8, 0, 1, 0, "t2b2", 0, 0, 1, 7);
        for (int i = 0; i < 3; i++)
            step(0, 1, SEQ, I8, 0, 0, 0, "t2wait", 0, 0, 1, 6);
        step(0, 1, SEQ, I8, 0, 1, 0, "t2b3", 0, 0, 1, 6);
        for (int b = 5; b >= 2; b--)
            step(0, 1, SEQ, I8, 0, 1, 0, "t2mid", 0, 0, 1, b);
        step(0, 1, SEQ, I8, 0, 1, 0, "t2b8", 1, 0, 1, 1);
        step(0, 1, IDL, SGL, 0, 1, 0, "t2end", 1, 0, 0, 0);

        // 3: undefined INCR, forced switch point on beat 16
        step(0, 1, NSQ, INC, 0, 1, 0, "t3b1", 0, 0, 0, 0);
        for (int k = 2; k <= 20; k++) begin
            if (k < 16)       step(0, 1, SEQ, INC, 0, 1, 0, "t3pre", 0, 0, 1, 0);
            else if (k == 16) step(0, 1, SEQ, INC, 0, 1, 0, "t3b16", 1, 1, 1, 0);
            else              step(0, 1, SEQ, INC, 0, 1, 0, "t3post", 1, 0, 0, 0);
        end
        step(0, 1, IDL, SGL, 0, 1, 0, "t3end", 1, 0, 0, 0);

        // BUSY limit inside INCR; an intervening SEQ clears the BUSY run
        step(0, 1, NSQ, INC, 0, 1, 0, "bl_ns", 0, 0, 0, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_b1", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_b2", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_b3", 0, 0, 1, 0);
        step(0, 1, SEQ, INC, 0, 1, 0, "bl_seq", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_c1", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_c2", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_c3", 0, 0, 1, 0);
        step(0, 1, BSY, INC, 0, 1, 0, "bl_c4", 1, 1, 1, 0);
        step(0, 1, IDL, SGL, 0, 1, 0, "bl_end", 1, 0, 0, 0);

        // 4: locked sequence of three SINGLEs, then unlock on IDLE
        step(0, 1, NSQ, SGL, 1, 1, 0, "t4s1", 0, 0, 0, 0);
        step(0, 1, NSQ, SGL, 1, 1, 0, "t4s2", 0, 0, 1, 0);
        step(0, 1, NSQ, SGL, 1, 1, 0, "t4s3", 0, 0, 1, 0);
        step(0, 1, IDL, SGL, 0, 1, 0, "t4rel", 1, 0, 1, 0);
        step(0, 1, IDL, SGL, 0, 1, 0, "t4end", 1, 0, 0, 0);

        // 5: WRAP16 with an error response on beat 5
        step(0, 1, NSQ, W16, 0, 1, 0, "t5b1", 0, 0, 0, 0);
        step(0, 1, SEQ, W16, 0, 1, 0, "t5b2", 0, 0, 1, 15);
        step(0, 1, SEQ, W16, 0, 1, 0, "t5b3", 0, 0, 1, 14);
        step(0, 1, SEQ, W16, 0, 1, 0, "t5b4", 0, 0, 1, 13);
        step(0, 1, SEQ, W16, 0, 0, 1, "t5err", 0, 0, 1, 12);
        step(0, 1, IDL, SGL, 0, 1, 1, "t5err2", 1, 0, 0, 0);
        step(0, 1, IDL, SGL, 0, 1, 0, "t5end", 1, 0, 0, 0);

        // 6: reset in the middle of INCR8
        step(0, 1, NSQ, I8, 0, 1, 0, "t6b1", 0, 0, 0, 0);
        step(0, 1, SEQ, I8, 0, 1, 0, "t6b2", 0, 0, 1, 7);
        step(0, 1, SEQ, I8, 0, 1, 0, "t6b3", 0, 0, 1, 6);
        step(1, 1, SEQ, I8, 0, 1, 0, "t6rst", 1, 0, 1, 5);
        step(0, 1, IDL, SGL, 0, 1, 0, "t6post", 1, 0, 0, 0);

        // Deselect inside a fixed burst: switch allowed, state holds
        step(0, 1, NSQ, W4, 0, 1, 0, "hs_b1", 0, 0, 0, 0);
        step(0, 0, SEQ, W4, 0, 1, 0, "hs_off", 1, 0, 1, 3);
        step(0, 1, SEQ, W4, 0, 1, 0, "hs_b2", 0, 0, 1, 3);
        step(0, 1, SEQ, W4, 0, 1, 0, "hs_b3", 0, 0, 1, 2);
        step(0, 1, SEQ, W4, 0, 1, 0, "hs_b4", 1, 0, 1, 1);
        step(0, 1, IDL, SGL, 0, 1, 0, "hs_end", 1, 0, 0, 0);

        repeat (2) @(posedge HCLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
